// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, tick-based debounce,
// press/release edge pulses and optional per-button auto-repeat.
module button_conditioner #(
  parameter int N_BTN              = 5,
  parameter int CLK_FREQ           = 100_000_000,
  parameter int TICK_HZ            = 1000,
  parameter int DEBOUNCE_TICKS     = 10,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(5'b00010)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             tick
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_TICKS < 2) ? 1
                    : $clog2(DEBOUNCE_TICKS);
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS)
                      ? REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW = (RMAX < 2) ? 1 : $clog2(RMAX);
  localparam logic [PW-1:0] PLIM = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DBLIM = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DLIM = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RLIM = RW'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RATE} rep_state_t;

  logic [PW-1:0]    pcnt;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] level_q;
  logic [DW-1:0]    dcnt [N_BTN];

  assign tick = (pcnt == PLIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // A disagreement must survive DEBOUNCE_TICKS ticks in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level <= '0;
      level_q   <= '0;
      for (int i = 0; i < N_BTN; i++) dcnt[i] <= '0;
    end else begin
      level_q <= btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_level[i]) begin
          dcnt[i] <= '0;
        end else if (tick) begin
          if (dcnt[i] == DBLIM) begin
            btn_level[i] <= s2[i];
            dcnt[i]      <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign btn_press   = btn_level & ~level_q;
  assign btn_release = ~btn_level & level_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t    st;
      rep_state_t    st_n;
      logic [RW-1:0] cnt;
      logic [RW-1:0] cnt_n;
      logic [RW-1:0] lim;
      logic          pulse;

      always_ff @(posedge clk) begin
        if (reset) begin
          st  <= IDLE;
          cnt <= '0;
        end else begin
          st  <= st_n;
          cnt <= cnt_n;
        end
      end

      always_comb begin
        st_n  = st;
        cnt_n = cnt;
        pulse = 1'b0;
        lim   = (st == DELAY) ? DLIM : RLIM;
        unique case (st)
          IDLE: begin
            if (btn_press[i]) begin
              st_n  = DELAY;
              cnt_n = '0;
              pulse = 1'b1;
            end
          end
          DELAY, RATE: begin
            if (!btn_level[i]) begin
              st_n  = IDLE;
              cnt_n = '0;
            end else if (tick) begin
              if (cnt == lim) begin
                st_n  = RATE;
                cnt_n = '0;
                pulse = 1'b1;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
          end
          default: begin
            st_n  = IDLE;
            cnt_n = '0;
          end
        endcase
      end

      assign btn_repeat[i] = pulse;
    end else begin : g_norep
      assign btn_repeat[i] = btn_press[i];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a
// tick-counting reference model.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int TD = 10;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam logic [NB-1:0] MASK = 5'b00010;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;
  logic          tick;

  button_conditioner #(
    .N_BTN(NB),
    .CLK_FREQ(10_000),
    .TICK_HZ(1000),
    .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY_TICKS(RD),
    .REPEAT_RATE_TICKS(RR),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  int            cyc;
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_lvlq;
  int            m_dc [NB];
  bit            m_act [NB];
  int            m_tk [NB];
  logic [20:0]   exp_v;
  wire  [20:0]   dut_v = {tick, btn_level, btn_press,
                          btn_release, btn_repeat};

  // Repeat pulses land on the RD-th tick after the press,
  // then every RR ticks.
  function automatic bit is_rep(int k);
    return (k == RD) || (k > RD && (k - RD) % RR == 0);
  endfunction

  task automatic step();
    logic [NB-1:0] r, ol, olq, prs, ep, er, erp;
    logic rs;
    bit t, et;
    r  = btn_raw;
    rs = reset;
    @(posedge clk);
    #1;
    ncyc++;
    if (rs) begin
      cyc = 0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlq = '0;
      for (int i = 0; i < NB; i++) begin
        m_dc[i] = 0; m_act[i] = 0; m_tk[i] = 0;
      end
    end else begin
      t   = (cyc % TD == TD - 1);
      ol  = m_lvl;
      olq = m_lvlq;
      prs = ol & ~olq;
      m_lvlq = ol;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] == ol[i]) m_dc[i] = 0;
        else if (t) begin
          if (m_dc[i] == DB - 1) begin
            m_lvl[i] = m_s2[i];
            m_dc[i]  = 0;
          end else m_dc[i]++;
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
      for (int i = 0; i < NB; i++) begin
        if (!m_act[i]) begin
          if (prs[i]) begin m_act[i] = 1; m_tk[i] = 0; end
        end else if (!ol[i]) m_act[i] = 0;
        else if (t) m_tk[i]++;
      end
      cyc++;
    end
    et = (cyc % TD == TD - 1);
    ep = m_lvl & ~m_lvlq;
    er = ~m_lvl & m_lvlq;
    for (int i = 0; i < NB; i++) begin
      if (MASK[i])
        erp[i] = (ep[i] & !m_act[i]) |
                 (m_act[i] & m_lvl[i] & et & is_rep(m_tk[i] + 1));
      else
        erp[i] = ep[i];
    end
    exp_v = {et, m_lvl, ep, er, erp};
  endtask

  task automatic test_reset();
    int n;
    btn_raw = '0;
    reset = 1'b1;
    step();
    step();
    total++;
    if (dut_v !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", dut_v);
    end
    reset = 1'b0;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (tick && n < 0) n = k + 1;
    end
    total++;
    if (n !== TD - 1) begin
      bad++;
      $display("FAIL first_tick got=%0d want=%0d", n, TD - 1);
    end
  endtask

  task automatic test_press_release();
    int lat, np, nr, nt;
    lat = -1; np = 0; nt = 0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (btn_level[0] && lat < 0) lat = k + 1;
      np += int'(btn_press[0]);
      nt += int'(tick);
    end
    total++;
    if (lat < 23 || lat > 32) begin
      bad++;
      $display("FAIL rise_latency got=%0d want=23..32", lat);
    end
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL press_count got=%0d want=1", np);
    end
    total++;
    if (nt !== 20) begin
      bad++;
      $display("FAIL tick_count got=%0d want=20", nt);
    end
    btn_raw[0] = 1'b0;
    lat = -1; nr = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (!btn_level[0] && lat < 0) lat = k + 1;
      nr += int'(btn_release[0]);
    end
    total++;
    if (lat < 23 || lat > 32 || nr !== 1) begin
      bad++;
      $display("FAIL fall got lat=%0d rel=%0d want 23..32/1", lat, nr);
    end
  endtask

  task automatic test_bounce();
    int np, lat;
    np = 0;
    for (int s = 0; s < 14; s++) begin
      btn_raw[2] = (s % 2 == 0);
      for (int k = 0; k < 7; k++) begin
        step();
        total++;
        if (dut_v !== exp_v) begin
          bad++;
          $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
        end
        np += int'(btn_press[2] | btn_release[2] | btn_level[2]);
      end
    end
    total++;
    if (np !== 0) begin
      bad++;
      $display("FAIL bounce_quiet got=%0d want=0", np);
    end
    btn_raw[2] = 1'b1;
    np = 0; lat = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (btn_press[2]) begin np++; lat = k + 1; end
    end
    total++;
    if (np !== 1 || lat > 32 || lat < 23) begin
      bad++;
      $display("FAIL bounce_press got n=%0d lat=%0d want 1/23..32",
               np, lat);
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 40; k++) step();
  endtask

  task automatic test_glitch();
    int n;
    n = 0;
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 75; k++) begin
      if (k == 15) btn_raw[3] = 1'b0;
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      n += int'(btn_level[3] | btn_press[3] | btn_release[3]);
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL glitch got=%0d want=0", n);
    end
  endtask

  task automatic test_repeat();
    int q[$];
    int pc, rc, gaps_bad;
    pc = -1; rc = -1; gaps_bad = 0;
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 260; k++) begin
      if (k == 200) btn_raw[1] = 1'b0;
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (btn_repeat[1]) q.push_back(k);
      if (btn_press[1]) pc = k;
      if (btn_release[1]) rc = k;
    end
    total++;
    if (q.size() < 3 || q[0] !== pc) begin
      bad++;
      $display("FAIL rep_first got n=%0d pc=%0d", q.size(), pc);
    end else begin
      total++;
      if (q[1] - q[0] < 41 || q[1] - q[0] > 50) begin
        bad++;
        $display("FAIL rep_delay got=%0d want=41..50", q[1] - q[0]);
      end
      for (int j = 2; j < q.size(); j++)
        if (q[j] - q[j-1] != 20) gaps_bad++;
      total++;
      if (gaps_bad !== 0 || rc < 0 || q[q.size()-1] >= rc) begin
        bad++;
        $display("FAIL rep_rate got badgaps=%0d last=%0d rel=%0d",
                 gaps_bad, q[q.size()-1], rc);
      end
    end
  endtask

  task automatic test_simul_reset();
    int p0, p4, lat;
    p0 = -1; p4 = -1; lat = -1;
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (btn_press[0]) p0 = k;
      if (btn_press[4]) p4 = k;
    end
    total++;
    if (p0 < 0 || p0 !== p4) begin
      bad++;
      $display("FAIL simul got p0=%0d p4=%0d want equal", p0, p4);
    end
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 100; k++) step();
    reset = 1'b1;
    step();
    total++;
    if (dut_v !== 21'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=0", dut_v);
    end
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
      if (btn_press[1] && lat < 0) lat = k + 1;
    end
    total++;
    if (lat < 23 || lat > 32) begin
      bad++;
      $display("FAIL post_reset_press got=%0d want=23..32", lat);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(24) == 0) btn_raw[i] = ~btn_raw[i];
      reset = ($urandom_range(499) == 0);
      step();
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL model c=%0d got=%b want=%b", ncyc, dut_v, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    btn_raw = '0;
    reset = 1'b1;
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_repeat();
    test_simul_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart of the display/audio output path for the board's user interface.
- Takes raw, asynchronous, bouncing push-button levels from the board and synchronises and debounces each one.
- Produces clean one-cycle press/release pulses and an optional auto-repeat pulse stream, used, for example, to step time fields while a button is held.
- Replaces ad-hoc previous-value edge detection in the top level; all buttons are handled independently by identical per-button logic.

Parameters:
- N_BTN, 5, number of buttons handled.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- TICK_HZ, 1000, internal timebase rate; TICK_DIV = CLK_FREQ/TICK_HZ, integer, >= 2.
- DEBOUNCE_TICKS, 10, consecutive ticks an input must differ from the debounced level before the level flips.
- REPEAT_DELAY_TICKS, 500, ticks from press to first auto-repeat pulse.
- REPEAT_RATE_TICKS, 100, ticks between subsequent auto-repeat pulses.
- REPEAT_MASK, 5'b00010, per-button auto-repeat enable; bit i = 1 enables repeat for button i.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_raw, input, N_BTN, raw asynchronous button levels (1 = pressed).
- btn_level, output, N_BTN, debounced button level.
- btn_press, output, N_BTN, one-cycle pulse on each debounced 0->1 transition.
- btn_release, output, N_BTN, one-cycle pulse on each debounced 1->0 transition.
- btn_repeat, output, N_BTN, one-cycle pulse at press, then auto-repeat pulses while held (masked buttons only; unmasked buttons equal btn_press).
- tick, output, 1, one-cycle timebase pulse, exported for debug/test.

Behaviour:
- Reset (synchronous, active-high):
  - Prescaler, sync flops, debounced levels, debounce counters and repeat counters are cleared to 0; repeat FSMs go to IDLE.
  - All outputs read 0 in the cycle after reset is sampled high.
  - Reset asserted mid-operation aborts everything; no pulse is emitted on its account.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 exactly when the count equals TICK_DIV-1; after reset, the first tick is in cycle TICK_DIV-1.
- Synchroniser: two flops per bit; sync[i] = btn_raw[i] delayed 2 cycles. No other logic uses btn_raw.
- Debounce, per button:
  - If sync[i] == btn_level[i], the counter clears to 0 every cycle.
  - Otherwise the counter increments on tick.
  - On the tick where the counter == DEBOUNCE_TICKS-1, btn_level[i] <= sync[i] and the counter clears.
  - Any bounce back to the current level restarts the count.
  - Resulting latency from a stable raw change to btn_level: 2 + (DEBOUNCE_TICKS-1)*TICK_DIV + 1 .. 2 + DEBOUNCE_TICKS*TICK_DIV cycles.
- Edges:
  - btn_press[i] = btn_level[i] & ~level_q[i], where level_q is btn_level delayed 1 cycle.
  - btn_release[i] = ~btn_level[i] & level_q[i].
  - Both are combinational from registers and never 1 for two consecutive cycles.
- Repeat FSM, per masked button; states IDLE, DELAY, RATE:
  - IDLE -> DELAY on btn_press: btn_repeat pulses that cycle; repeat counter loads 0, and any coincident tick is ignored.
  - DELAY: counter increments on tick. On the tick where counter == REPEAT_DELAY_TICKS-1: pulse, counter 0, go to RATE.
  - RATE: same rule with REPEAT_RATE_TICKS-1; stays in RATE.
  - DELAY/RATE -> IDLE when btn_level[i] == 0 (cycle of btn_release); no pulse, counter 0.
  - Repeat pulses are tick-aligned. RATE pulse spacing is exactly REPEAT_RATE_TICKS*TICK_DIV cycles. The press-to-first-repeat interval is (REPEAT_DELAY_TICKS-1)*TICK_DIV+1 .. REPEAT_DELAY_TICKS*TICK_DIV cycles.
- Unmasked buttons: btn_repeat[i] == btn_press[i] and no FSM activity.
- Buttons are fully independent; simultaneous presses produce simultaneous independent pulses.
- A button held through reset release is seen as a fresh press once debounced.
- Counter widths are sized by $clog2 of the respective parameter; no counter may wrap silently.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=10_000, TICK_HZ=1000 (TICK_DIV=10), DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, REPEAT_MASK=5'b00010.
- Clean press/release: after reset, raw[0] = 1 held for 200 cycles, then 0 -> tick pulses at cycles 9, 19, 29, …. btn_level[0] rises 23–32 cycles after the raw edge, with one btn_press[0] pulse. btn_level[0] falls 23–32 cycles after the raw fall, with one btn_release[0] pulse. btn_repeat[0] equals btn_press[0].
- Bounce rejection: raw[2] toggles every 7 cycles for 100 cycles, then holds 1 -> no pulses during the toggling. Exactly one btn_press[2] pulse, within 32 cycles of the final edge.
- Short glitch: raw[3] = 1 for 15 cycles only -> btn_level[3] stays 0; no press or release pulse.
- Auto-repeat: raw[1] held 1 for 200 cycles -> btn_repeat[1] pulses at press, the first repeat 41–50 cycles later, then every 20 cycles. Stops at release with no extra pulse.
- Simultaneous and reset: raw[0] and raw[4] rise in the same cycle -> btn_press[0] and btn_press[4] pulse in the same cycle. Then assert reset during the repeat run with raw[1] still held -> all outputs 0 the next cycle. After reset is released, a fresh btn_press[1] pulse occurs 23–32 cycles later.
